// File: rtl/odejmator_16_bit.sv
// Sequential W-bit subtractor: o = a + ~b + 1, one lookahead slice per clock.
// LSB slice first, borrow registered between slices, valid/ready on both sides.
module odejmator_16_bit #(
   parameter int W     = 16,
   parameter int SLICE = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:W-1] a,
   input  logic [0:W-1] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:W-1] o,
   output logic         borrow,
   output logic         ovf,
   output logic         zero
);

   localparam int NS = W / SLICE;
   localparam int CW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [0:W-1]  a_q, a_d;
   logic [0:W-1]  b_q, b_d;
   logic [0:W-1]  o_q, o_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          c_q, c_d;
   logic          borrow_q, borrow_d;
   logic          ovf_q, ovf_d;
   logic          zero_q, zero_d;

   logic [W-1:0]     a_v, b_v, o_v;
   logic [W-1:0]     a_sh, b_sh;
   logic [W-1:0]     msk, ins;
   logic [SLICE-1:0] sg, sp, ss;
   logic [SLICE:0]   sc;
   logic             pr, ac;
   logic [0:W-1]     o_nxt;

   // Current slice: flat generate/propagate lookahead and merged result word
   always_comb begin
      a_v  = a_q;
      b_v  = b_q;
      o_v  = o_q;
      a_sh = a_v >> (SLICE * cnt_q);
      b_sh = b_v >> (SLICE * cnt_q);
      sg   = a_sh[SLICE-1:0] & ~b_sh[SLICE-1:0];
      sp   = a_sh[SLICE-1:0] ^ ~b_sh[SLICE-1:0];
      sc   = '0;
      sc[0] = c_q;
      pr   = 1'b1;
      ac   = 1'b0;
      for (int i = 0; i < SLICE; i++) begin
         pr = 1'b1;
         ac = 1'b0;
         for (int j = i; j >= 0; j--) begin
            ac = ac | (sg[j] & pr);
            pr = pr & sp[j];
         end
         sc[i+1] = ac | (pr & c_q);
      end
      ss    = sp ^ sc[SLICE-1:0];
      msk   = W'({SLICE{1'b1}}) << (SLICE * cnt_q);
      ins   = W'(ss) << (SLICE * cnt_q);
      o_nxt = (o_v & ~msk) | ins;
   end

   // Handshake FSM, operand capture, slice stepping and flag update
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      o_d      = o_q;
      cnt_d    = cnt_q;
      c_d      = c_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               o_d      = '0;
               cnt_d    = '0;
               c_d      = 1'b1;
               borrow_d = 1'b0;
               ovf_d    = 1'b0;
               zero_d   = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            o_d = o_nxt;
            c_d = sc[SLICE];
            if (cnt_q == LAST) begin
               borrow_d = ~sc[SLICE];
               ovf_d    = (a_q[0] != b_q[0]) &&
                          (o_nxt[0] != a_q[0]);
               zero_d   = (o_nxt == '0);
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         o_q      <= '0;
         cnt_q    <= '0;
         c_q      <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         o_q      <= o_d;
         cnt_q    <= cnt_d;
         c_q      <= c_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign o         = o_q;
   assign borrow    = borrow_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_odejmator_16_bit.sv
// Randomized bench for odejmator_16_bit against an arithmetic model.
// Scoreboard queue of accepted operands; one negedge compare process.
module tb_odejmator_16_bit;
   localparam int W     = 16;
   localparam int SLICE = 4;
   localparam int NS    = W / SLICE;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [0:W-1] a;
   logic [0:W-1] b;
   logic         out_valid;
   logic         out_ready;
   logic [0:W-1] o;
   logic         borrow;
   logic         ovf;
   logic         zero;

   odejmator_16_bit #(.W(W), .SLICE(SLICE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .borrow    (borrow),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      int          acc;
      bit          lit;
      logic [15:0] lo;
      logic [2:0]  lf;
   } exp_t;

   exp_t q[$];

   // {difference, borrow, ovf, zero} from plain integer arithmetic
   function automatic logic [18:0] model(logic [15:0] x, logic [15:0] y);
      int          d;
      logic [15:0] r;
      d = int'($signed(x)) - int'($signed(y));
      r = x - y;
      return {r, x < y, (d > 32767) || (d < -32768), r == 16'h0};
   endfunction

   bit rnd_rdy   = 1'b0;
   bit rdy_force = 1'b1;

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
         else out_ready = rdy_force;
      end
   end

   initial begin
      logic [18:0] m;
      bit          prev_ov;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_ov = 1'b0;
         end else if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", out_valid, 0);
            end else begin
               m = model(q[0].x, q[0].y);
               if (!prev_ov) chk("latency", cyc - q[0].acc, NS);
               chk("o", o, m[18:3]);
               chk("flags", {borrow, ovf, zero}, m[2:0]);
               if (q[0].lit) begin
                  chk("lit_o", o, q[0].lo);
                  chk("lit_flags", {borrow, ovf, zero}, q[0].lf);
               end
               chk("in_ready_busy", in_ready, 0);
               if (out_ready) void'(q.pop_front());
            end
            prev_ov = 1'b1;
         end else begin
            prev_ov = 1'b0;
         end
      end
   end

   task automatic op(logic [15:0] x, logic [15:0] y, bit lit = 0,
                     logic [15:0] lo = 0, logic [2:0] lf = 0);
      bit   done;
      exp_t e;
      done = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = x;
      b = y;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (in_ready && rst_n) begin
            done  = 1'b1;
            e.x   = x;
            e.y   = y;
            e.acc = cyc + 1;
            e.lit = lit;
            e.lo  = lo;
            e.lf  = lf;
            q.push_back(e);
         end
      end
      if (!done) chk("accept_timeout", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && q.size() > 0; k++) @(negedge clk);
      if (q.size() > 0) chk("drain_timeout", q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] x, y;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_o", o, 0);
      chk("rst_flags", {borrow, ovf, zero}, 0);
      #3 rst_n = 1'b1;

      op(16'h1234, 16'h0234, 1, 16'h1000, 3'b000);
      op(16'h0000, 16'h0001, 1, 16'hFFFF, 3'b100);
      op(16'h8000, 16'h0001, 1, 16'h7FFF, 3'b010);
      op(16'hABCD, 16'hABCD, 1, 16'h0000, 3'b001);
      drain();

      rdy_force = 1'b0;
      @(posedge clk);
      #2;
      op(16'h1357, 16'h2468, 1, 16'hEEEF, 3'b100);
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      @(posedge clk);
      #2;
      in_valid = 1'b1;
      a = 16'hFFFF;
      b = 16'h0001;
      repeat (6) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_o", o, 16'hEEEF);
      end
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      rdy_force = 1'b1;
      op(16'hFFFF, 16'h0001, 1, 16'hFFFE, 3'b000);
      drain();

      op(16'h1111, 16'h2222);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_o", o, 0);
      chk("arst_flags", {borrow, ovf, zero}, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("arst_no_pulse", out_valid, 0);
      end
      op(16'h0005, 16'h0003, 1, 16'h0002, 3'b000);
      drain();

      rnd_rdy = 1'b1;
      for (int n = 0; n < 40; n++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         if (n % 8 == 3) y = x;
         if (n % 8 == 5) x = 16'h8000;
         if (n % 8 == 6) y = 16'hFFFF;
         op(x, y);
      end
      rnd_rdy = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
